// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SELECT  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_SHOW    = 2'd3
    } state_e;

    localparam int              BIN_W     = 14;
    localparam logic [3:0]      BCD_BLANK = 4'hF;
    localparam logic [BIN_W-1:0] MAX_DEC  = 14'd9999;

    // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
    function automatic logic [15:0] dabble_add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int k = 0; k < 4; k++) begin
            if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (one shift/add-3 step per cycle).
module bin2bcd_seq
    import seg_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd
);

    logic [BIN_W-1:0] bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [15:0]      adj;

    // Load on start, then shift one bit per cycle; done fires on the last step only.
    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        adj    = dabble_add3(bcd_q);
        if (start) begin
            bin_d = bin;
            bcd_d = '0;
            cnt_d = 4'd14;
        end else if (cnt_q != 4'd0) begin
            bcd_d  = {adj[14:0], bin_q[BIN_W-1]};
            bin_d  = {bin_q[BIN_W-2:0], 1'b0};
            cnt_d  = cnt_q - 4'd1;
            done_d = (cnt_q == 4'd1);
        end
    end

    // Converter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign busy = (cnt_q != 4'd0);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_scheduler.sv
// Arbitrates the shared 4-digit display between requesters and drives BCD digits.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | no owner, display blank, waiting for any request
//  ST_SELECT  | pick winner (priority first, else round-robin), start convert
//  ST_CONVERT | double-dabble in flight; all requester events deferred
//  ST_SHOW    | digits valid; refresh on tick, or leave for SELECT on exit rule
module seg_display_scheduler
    import seg_disp_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int TICK_DIV = 100000,
    parameter int DWELL    = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       pri,
    input  logic [N_REQ*BIN_W-1:0] values,
    output logic [N_REQ-1:0]       grant,
    output logic [15:0]            bcd_out,
    output logic                   out_valid,
    output logic                   busy
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DWELL_W = $clog2(DWELL + 1);

    state_e             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [IDX_W-1:0]   rr_q, rr_d, owner_q, owner_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [15:0]        bcd_q, bcd_d;
    logic               valid_q, valid_d;

    logic               tick;
    logic [IDX_W-1:0]   win, sel_idx;
    logic               found;
    logic [IDX_W:0]     cand;
    logic [2*N_REQ-1:0] req_rot;
    logic [BIN_W-1:0]   raw, conv_bin;
    logic               conv_start, conv_busy, conv_done;
    logic [15:0]        conv_bcd;
    logic               own_req, own_pri, other_pri, other_req, leave;

    function automatic logic [15:0] blank_lz(input logic [15:0] b);
        logic [15:0] r;
        logic        lead;
        r    = b;
        lead = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            if (lead && (b[4*k +: 4] == 4'd0)) r[4*k +: 4] = BCD_BLANK;
            else lead = 1'b0;
        end
        return r;
    endfunction

    assign tick = (tick_q == TICK_W'(TICK_DIV - 1));

    // Arbiter: lowest-index priority requester, else first request at/after rr pointer.
    always_comb begin
        win     = '0;
        found   = 1'b0;
        cand    = '0;
        req_rot = {req, req} >> rr_q;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && pri[i]) begin
                win   = IDX_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_rot[i]) begin
                cand = (IDX_W+1)'(rr_q) + (IDX_W+1)'(i);
                if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
                win   = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

    // Value mux and saturation; the converter latches this on start.
    always_comb begin
        raw     = '0;
        sel_idx = (state_q == ST_SELECT) ? win : owner_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) raw = values[i*BIN_W +: BIN_W];
        end
        conv_bin = (raw > MAX_DEC) ? MAX_DEC : raw;
    end

    assign own_req   = req[owner_q];
    assign own_pri   = own_req && pri[owner_q];
    assign other_pri = |(req & pri & ~grant_q);
    assign other_req = |(req & ~grant_q);
    assign leave     = !own_req || (other_pri && !own_pri) ||
                       ((dwell_q == DWELL_W'(DWELL)) && !own_pri && other_req);

    // Next-state, grant, dwell and display logic.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick ? '0 : tick_q + 1'b1;
        dwell_d    = dwell_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        bcd_d      = bcd_q;
        valid_d    = 1'b0;
        conv_start = 1'b0;
        if (tick && (state_q == ST_CONVERT || state_q == ST_SHOW) &&
            (dwell_q != DWELL_W'(DWELL)))
            dwell_d = dwell_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                bcd_d   = {4{BCD_BLANK}};
                if (|req) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (!(|req)) begin
                    grant_d = '0;
                    bcd_d   = {4{BCD_BLANK}};
                    state_d = ST_IDLE;
                end else begin
                    grant_d    = N_REQ'(1) << win;
                    owner_d    = win;
                    dwell_d    = '0;
                    conv_start = 1'b1;
                    state_d    = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    bcd_d   = (BLANK_LZ != 0) ? blank_lz(conv_bcd) : conv_bcd;
                    valid_d = 1'b1;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (leave) begin
                    rr_d    = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d = ST_SELECT;
                end else if (tick) begin
                    conv_start = 1'b1;
                    state_d    = ST_CONVERT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            dwell_q <= '0;
            rr_q    <= '0;
            owner_q <= '0;
            grant_q <= '0;
            bcd_q   <= {4{BCD_BLANK}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            dwell_q <= dwell_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign grant     = grant_q;
    assign bcd_out   = bcd_q;
    assign out_valid = valid_q;
    assign busy      = conv_busy;

endmodule
